axi_uartlite_tx_sequencer: RTL and testbench

- AXI4 master controller that turns a byte stream into single-beat AXI transactions against a 32-bit AXI UART Lite slave. That slave sits on the 32-bit side of the 64-to-32 width converter or directly on a 32-bit interconnect.
- For each byte it polls the UART status register until the TX FIFO has room, writes the byte to the TX FIFO register, and waits for the write response.
- It serves as the tty output engine for the test design.

---
 rtl/axi_uartlite_tx_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_axi_uartlite_tx_sequencer.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_uartlite_tx_sequencer.sv
// Byte-stream to AXI UART Lite driver: polls the status register until the TX
// FIFO has room, writes one byte to the TX FIFO, then waits for the response.
module axi_uartlite_tx_sequencer #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned POLL_LIMIT = 1024,
  parameter int unsigned FULL_BIT   = 3
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [7:0]  s_tx_data,
  input  logic        s_tx_valid,
  output logic        s_tx_ready,
  output logic        busy,
  output logic        err_timeout,
  output logic        err_resp,
  output logic [31:0] m_axi_awaddr,
  output logic [7:0]  m_axi_awlen,
  output logic [2:0]  m_axi_awsize,
  output logic [1:0]  m_axi_awburst,
  output logic        m_axi_awlock,
  output logic [3:0]  m_axi_awcache,
  output logic [2:0]  m_axi_awprot,
  output logic [3:0]  m_axi_awregion,
  output logic [3:0]  m_axi_awqos,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wlast,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [31:0] m_axi_araddr,
  output logic [7:0]  m_axi_arlen,
  output logic [2:0]  m_axi_arsize,
  output logic [1:0]  m_axi_arburst,
  output logic        m_axi_arlock,
  output logic [3:0]  m_axi_arcache,
  output logic [2:0]  m_axi_arprot,
  output logic [3:0]  m_axi_arregion,
  output logic [3:0]  m_axi_arqos,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rlast,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR,
    S_WR_RESP
  } state_t;

  localparam logic [15:0] POLL_LIMIT_W = 16'(POLL_LIMIT);

  state_t      state_q, state_d;
  logic [7:0]  byte_q, byte_d;
  logic [15:0] poll_cnt_q, poll_cnt_d;
  logic [15:0] poll_inc;
  logic        tx_ready_q, tx_ready_d;
  logic        busy_q, busy_d;
  logic        err_to_q, err_to_d;
  logic        err_resp_q, err_resp_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic        aw_done, w_done;

  // rlast is meaningless for single-beat reads; only one status bit matters.
  logic unused_inputs;
  assign unused_inputs = ^{m_axi_rlast, m_axi_rdata};

  assign m_axi_awlen    = 8'd0;
  assign m_axi_awsize   = 3'b010;
  assign m_axi_awburst  = 2'b01;
  assign m_axi_awlock   = 1'b0;
  assign m_axi_awcache  = 4'b0011;
  assign m_axi_awprot   = 3'b000;
  assign m_axi_awregion = 4'd0;
  assign m_axi_awqos    = 4'd0;
  assign m_axi_arlen    = 8'd0;
  assign m_axi_arsize   = 3'b010;
  assign m_axi_arburst  = 2'b01;
  assign m_axi_arlock   = 1'b0;
  assign m_axi_arcache  = 4'b0011;
  assign m_axi_arprot   = 3'b000;
  assign m_axi_arregion = 4'd0;
  assign m_axi_arqos    = 4'd0;

  assign m_axi_araddr  = BASE_ADDR + 32'd8;
  assign m_axi_awaddr  = BASE_ADDR + 32'd4;
  assign m_axi_wdata   = {24'h0, byte_q};
  assign m_axi_wstrb   = 4'b0001;
  assign m_axi_wlast   = 1'b1;

  assign s_tx_ready    = tx_ready_q;
  assign busy          = busy_q;
  assign err_timeout   = err_to_q;
  assign err_resp      = err_resp_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;

  // Saturating so a huge POLL_LIMIT can never alias through a wrap.
  assign poll_inc = (poll_cnt_q == 16'hFFFF) ? poll_cnt_q : poll_cnt_q + 16'd1;
  assign aw_done  = !awvalid_q || m_axi_awready;
  assign w_done   = !wvalid_q || m_axi_wready;

  always_comb begin
    state_d    = state_q;
    byte_d     = byte_q;
    poll_cnt_d = poll_cnt_q;
    err_to_d   = err_to_q;
    err_resp_d = err_resp_q;
    case (state_q)
      S_IDLE: begin
        if (s_tx_valid && tx_ready_q) begin
          byte_d     = s_tx_data;
          poll_cnt_d = 16'd0;
          state_d    = S_RD_ADDR;
        end
      end
      S_RD_ADDR: begin
        if (arvalid_q && m_axi_arready) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (rready_q && m_axi_rvalid) begin
          if (m_axi_rresp != 2'b00) begin
            err_resp_d = 1'b1;
            state_d    = S_IDLE;
          end else if (m_axi_rdata[FULL_BIT]) begin
            poll_cnt_d = poll_inc;
            if (poll_inc == POLL_LIMIT_W) begin
              err_to_d = 1'b1;
              state_d  = S_IDLE;
            end else begin
              state_d = S_RD_ADDR;
            end
          end else begin
            state_d = S_WR;
          end
        end
      end
      S_WR: begin
        if (aw_done && w_done) state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        if (bready_q && m_axi_bvalid) begin
          if (m_axi_bresp != 2'b00) err_resp_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Every control output is the registered image of the state being entered.
    tx_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
    arvalid_d  = (state_d == S_RD_ADDR);
    rready_d   = (state_d == S_RD_DATA);
    bready_d   = (state_d == S_WR_RESP);
    awvalid_d  = (state_d == S_WR) && ((state_q != S_WR) || (awvalid_q && !m_axi_awready));
    wvalid_d   = (state_d == S_WR) && ((state_q != S_WR) || (wvalid_q && !m_axi_wready));
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= S_IDLE;
      byte_q     <= 8'd0;
      poll_cnt_q <= 16'd0;
      tx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      err_to_q   <= 1'b0;
      err_resp_q <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_q     <= byte_d;
      poll_cnt_q <= poll_cnt_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      err_to_q   <= err_to_d;
      err_resp_q <= err_resp_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
    end
  end

endmodule

// File: tb/tb_axi_uartlite_tx_sequencer.sv
// Randomised bench: a stimulus model queues expected AXI traffic, an AXI slave
// model with random latencies pops and compares it as handshakes complete.
module tb_axi_uartlite_tx_sequencer;

  localparam logic [31:0] BASE = 32'h4060_0000;
  localparam int PL = 4;
  localparam int FB = 3;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [7:0]  s_tx_data = 8'h00;
  logic        s_tx_valid = 1'b0;
  logic        s_tx_ready, busy, err_timeout, err_resp;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr;
  logic [7:0]  m_axi_awlen, m_axi_arlen;
  logic [2:0]  m_axi_awsize, m_axi_awprot, m_axi_arsize, m_axi_arprot;
  logic [1:0]  m_axi_awburst, m_axi_arburst;
  logic        m_axi_awlock, m_axi_arlock;
  logic [3:0]  m_axi_awcache, m_axi_awregion, m_axi_awqos;
  logic [3:0]  m_axi_arcache, m_axi_arregion, m_axi_arqos;
  logic        m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_arvalid, m_axi_rready;
  logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_bvalid = 1'b0;
  logic [1:0]  m_axi_bresp = 2'b00, m_axi_rresp = 2'b00;
  logic        m_axi_arready = 1'b0, m_axi_rvalid = 1'b0, m_axi_rlast = 1'b1;
  logic [31:0] m_axi_rdata = 32'h0;

  always #5 aclk = ~aclk;

  axi_uartlite_tx_sequencer #(
    .BASE_ADDR(BASE), .POLL_LIMIT(PL), .FULL_BIT(FB)
  ) dut (
    .aclk(aclk), .areset(areset),
    .s_tx_data(s_tx_data), .s_tx_valid(s_tx_valid), .s_tx_ready(s_tx_ready),
    .busy(busy), .err_timeout(err_timeout), .err_resp(err_resp),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock), .m_axi_awcache(m_axi_awcache),
    .m_axi_awprot(m_axi_awprot), .m_axi_awregion(m_axi_awregion), .m_axi_awqos(m_axi_awqos),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock), .m_axi_arcache(m_axi_arcache),
    .m_axi_arprot(m_axi_arprot), .m_axi_arregion(m_axi_arregion), .m_axi_arqos(m_axi_arqos),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  typedef struct packed {
    logic        is_wr;
    logic [31:0] data;
  } exp_t;

  int n_checks = 0;
  int n_fail = 0;

  exp_t        exp_q[$];
  logic [33:0] stat_q[$];
  logic [1:0]  bresp_q[$];
  bit          exp_err_resp = 0, exp_err_to = 0;
  int          exp_writes = 0, seen_aw = 0, seen_w = 0;
  int          fix_ar = -1, fix_r = -1, fix_aw = -1, fix_w = -1, fix_b = -1;
  int          last_aw_hi = 0, last_w_hi = 0;

  // Slave model state
  bit          ar_f = 0, r_f = 0, aw_f = 0, w_f = 0, b_f = 0;
  bit          rd_pend = 0, aw_done = 0, w_done = 0, b_pend = 0, w_pend_prev = 0;
  int          ar_cnt = 0, ar_dly = 0, r_cnt = 0, r_dly = 0, aw_cnt = 0, aw_dly = 0;
  int          w_cnt = 0, w_dly = 0, b_cnt = 0, b_dly = 0, aw_hi = 0, w_hi = 0;
  logic [31:0] wdata_prev = 32'h0;
  logic [33:0] stat_word = 34'h0;
  exp_t        got;

  function automatic void check(string nm, logic [63:0] act, logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endfunction

  function automatic void fail_now(string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got event expected none at %0t", nm, $time);
  endfunction

  function automatic int pick(int f);
    return (f >= 0) ? f : int'($urandom_range(0, 3));
  endfunction

  function automatic exp_t pop_exp(string nm);
    exp_t e;
    e = '0;
    if (exp_q.size() == 0) fail_now(nm);
    else e = exp_q.pop_front();
    return e;
  endfunction

  // AXI slave + monitor. Inputs change at negedge+1; a handshake flagged here
  // completes on the following posedge and is consumed on the next pass.
  initial begin
    forever begin
      @(negedge aclk);
      #1;
      if (b_f) begin
        check("ready_after_b", s_tx_ready, 1);
        check("idle_after_b", busy, 0);
      end
      if (ar_f) begin
        ar_cnt  = 0;
        rd_pend = 1;
        r_cnt   = 0;
        if (stat_q.size() > 0) stat_word = stat_q.pop_front();
        else begin
          fail_now("unexpected_status_read");
          stat_word = 34'h0;
        end
        m_axi_rresp = stat_word[33:32];
        m_axi_rdata = stat_word[31:0];
      end
      if (r_f) rd_pend = 0;
      if (aw_f) begin aw_cnt = 0; aw_done = 1; end
      if (w_f) begin w_cnt = 0; w_done = 1; end
      if (aw_done && w_done) begin
        aw_done = 0;
        w_done  = 0;
        b_pend  = 1;
        b_cnt   = 0;
        m_axi_bresp = (bresp_q.size() > 0) ? bresp_q.pop_front() : 2'b00;
      end
      if (b_f) b_pend = 0;

      if (areset) begin
        rd_pend = 0; aw_done = 0; w_done = 0; b_pend = 0; w_pend_prev = 0;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; aw_hi = 0; w_hi = 0;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_awready = 0;
        m_axi_wready = 0; m_axi_bvalid = 0;
        ar_f = 0; r_f = 0; aw_f = 0; w_f = 0; b_f = 0;
      end else begin
        m_axi_arready = 0;
        if (m_axi_arvalid) begin
          if (ar_cnt == 0) ar_dly = pick(fix_ar);
          m_axi_arready = (ar_cnt >= ar_dly);
          ar_cnt++;
        end
        m_axi_rvalid = 0;
        if (rd_pend) begin
          if (r_cnt == 0) r_dly = pick(fix_r);
          m_axi_rvalid = (r_cnt >= r_dly);
          r_cnt++;
        end
        m_axi_awready = 0;
        if (m_axi_awvalid) begin
          if (aw_cnt == 0) aw_dly = pick(fix_aw);
          m_axi_awready = (aw_cnt >= aw_dly);
          aw_cnt++;
        end
        m_axi_wready = 0;
        if (m_axi_wvalid) begin
          if (w_cnt == 0) w_dly = pick(fix_w);
          m_axi_wready = (w_cnt >= w_dly);
          w_cnt++;
        end
        m_axi_bvalid = 0;
        if (b_pend) begin
          if (b_cnt == 0) b_dly = pick(fix_b);
          m_axi_bvalid = (b_cnt >= b_dly);
          b_cnt++;
        end

        ar_f = m_axi_arvalid && m_axi_arready;
        r_f  = m_axi_rvalid && m_axi_rready;
        aw_f = m_axi_awvalid && m_axi_awready;
        w_f  = m_axi_wvalid && m_axi_wready;
        b_f  = m_axi_bvalid && m_axi_bready;

        if (m_axi_arvalid || m_axi_awvalid || m_axi_wvalid)
          check("ar_aw_exclusive", m_axi_arvalid && (m_axi_awvalid || m_axi_wvalid), 0);
        if (m_axi_bready)
          check("bready_after_write", m_axi_awvalid || m_axi_wvalid, 0);
        if (m_axi_wvalid && w_pend_prev)
          check("wdata_stable", m_axi_wdata, wdata_prev);
        w_pend_prev = m_axi_wvalid && !w_f;
        wdata_prev  = m_axi_wdata;

        if (m_axi_awvalid) aw_hi++;
        if (m_axi_wvalid) w_hi++;
        if (ar_f) begin
          got = pop_exp("unexpected_ar");
          check("ar_is_read", got.is_wr, 0);
          check("araddr", m_axi_araddr, BASE + 32'd8);
        end
        if (aw_f) begin
          check("awaddr", m_axi_awaddr, BASE + 32'd4);
          seen_aw++;
          last_aw_hi = aw_hi;
          aw_hi = 0;
        end
        if (w_f) begin
          got = pop_exp("unexpected_w");
          check("w_is_write", got.is_wr, 1);
          check("wdata", m_axi_wdata, got.data);
          check("wstrb", m_axi_wstrb, 4'b0001);
          check("wlast", m_axi_wlast, 1);
          seen_w++;
          last_w_hi = w_hi;
          w_hi = 0;
        end
      end
    end
  end

  task automatic wait_idle();
    int t;
    t = 0;
    while (!(busy === 1'b0 && s_tx_ready === 1'b1) && t < 2000) begin
      @(negedge aclk);
      t++;
    end
    if (t >= 2000) fail_now("idle_timeout");
  endtask

  // Reference model: walk the status words the slave will return and decide,
  // from the polling rules alone, which reads happen and whether a write follows.
  task automatic send_byte(input logic [7:0] d, input int n_full, input int err_idx,
                           input logic [1:0] err_rr, input logic [1:0] br, input bit wait_done);
    int reads, t;
    bit wr;
    logic [31:0] st;
    logic [1:0] rr;
    reads = 0;
    wr = 0;
    for (int i = 0; i <= n_full; i++) begin
      st = $urandom;
      st[FB] = (i < n_full);
      rr = (i == err_idx) ? err_rr : 2'b00;
      stat_q.push_back({rr, st});
      exp_q.push_back({1'b0, BASE + 32'd8});
      reads++;
      if (rr != 2'b00) begin
        exp_err_resp = 1;
        break;
      end
      if (!st[FB]) begin
        wr = 1;
        break;
      end
      if (reads == PL) begin
        exp_err_to = 1;
        break;
      end
    end
    if (wr) begin
      exp_q.push_back({1'b1, 24'h0, d});
      bresp_q.push_back(br);
      exp_writes++;
      if (br != 2'b00) exp_err_resp = 1;
    end
    $display("byte %02h: polls=%0d rresp_err=%0d write=%0d bresp=%0d", d, reads,
             (err_idx >= 0 && err_idx < reads) ? 1 : 0, wr, br);

    s_tx_data  = d;
    s_tx_valid = 1;
    t = 0;
    while (s_tx_ready !== 1'b1 && t < 1000) begin
      @(negedge aclk);
      t++;
    end
    if (t >= 1000) fail_now("accept_timeout");
    @(negedge aclk);
    s_tx_valid = 0;
    s_tx_data  = 8'($urandom);
    if (wait_done) begin
      wait_idle();
      check("err_resp", err_resp, exp_err_resp);
      check("err_timeout", err_timeout, exp_err_to);
      check("exp_drained", exp_q.size(), 0);
      check("aw_count", seen_aw, exp_writes);
      check("w_count", seen_w, exp_writes);
    end
  endtask

  task automatic random_byte();
    int nf, ei;
    logic [1:0] br;
    nf = int'($urandom_range(0, 5));
    ei = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, nf)) : -1;
    br = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
    send_byte(8'($urandom), nf, ei, 2'(($urandom_range(1, 3))), br, 1);
  endtask

  initial begin
    int t;
    repeat (3) @(negedge aclk);
    check("rst_s_tx_ready", s_tx_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_err", {err_resp, err_timeout}, 0);
    check("rst_valids", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready}, 0);
    areset = 0;
    @(negedge aclk);
    check("ready_after_reset", s_tx_ready, 1);
    check("arsize", m_axi_arsize, 3'b010);
    check("awburst", m_axi_awburst, 2'b01);
    check("arcache", m_axi_arcache, 4'b0011);
    check("awlen", m_axi_awlen, 8'd0);

    send_byte(8'h41, 0, -1, 2'b00, 2'b00, 1);
    send_byte(8'h17, 3, -1, 2'b00, 2'b00, 1);
    send_byte(8'h99, 4, -1, 2'b00, 2'b00, 1);
    send_byte(8'h42, 0, -1, 2'b00, 2'b00, 1);

    fix_aw = 3;
    fix_w  = 0;
    send_byte(8'h5A, 0, -1, 2'b00, 2'b00, 1);
    check("awvalid_cycles", last_aw_hi, 4);
    check("wvalid_cycles", last_w_hi, 1);
    fix_aw = -1;
    fix_w  = -1;

    send_byte(8'h33, 0, -1, 2'b00, 2'b10, 1);
    send_byte(8'h34, 1, 1, 2'b11, 2'b00, 1);

    repeat (40) random_byte();

    fix_b = 40;
    send_byte(8'h55, 0, -1, 2'b00, 2'b00, 0);
    t = 0;
    while (m_axi_bready !== 1'b1 && t < 500) begin
      @(negedge aclk);
      t++;
    end
    if (t >= 500) fail_now("reach_wr_resp_timeout");
    areset = 1;
    @(negedge aclk);
    check("mid_rst_valids", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready}, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_err", {err_resp, err_timeout}, 0);
    areset = 0;
    exp_q.delete();
    stat_q.delete();
    bresp_q.delete();
    exp_err_resp = 0;
    exp_err_to = 0;
    fix_b = -1;
    @(negedge aclk);
    check("ready_after_mid_rst", s_tx_ready, 1);

    repeat (5) random_byte();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish by %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
